instruction_fetch: RTL and testbench

- Fetch stage directly upstream of the decode/register-file stage.
- Holds the 64-bit PC and issues one 32-bit instruction read at a time to instruction memory over a req/ready + rvalid handshake.
- Presents each instruction with its PC to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and squashes the fetch in flight.

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time
// and hands each fetched word with its PC to decode; redirects squash.
module instruction_fetch #(
    parameter int unsigned            PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [31:0]         if_instruction,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                id_ready,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        ~{{(PC_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                discard_q, discard_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;

    logic [PC_WIDTH-1:0] target;
    logic                accept;

    // Redirect target is word aligned; low two bits of the request are dropped.
    assign target = branch_target & ALIGN_MASK;
    assign accept = imem_req && imem_ready;

    // Outputs come straight from state registers (reset only gates the request).
    assign imem_req       = (state_q == S_REQ) && !reset;
    assign imem_addr      = pc_q;
    assign if_valid       = (state_q == S_HOLD);
    assign if_instruction = instr_q;
    assign if_pc          = if_pc_q;

    // Next-state logic: a redirect always overrides the sequential PC update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        instr_d   = instr_q;
        if_pc_d   = if_pc_q;
        unique case (state_q)
            S_REQ: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                    if (branch_taken) begin
                        pc_d      = target;
                        discard_d = 1'b1;
                    end
                end else if (branch_taken) begin
                    pc_d = target;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (branch_taken) begin
                        pc_d      = target;
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        instr_d = imem_rdata;
                        if_pc_d = req_pc_q;
                        pc_d    = req_pc_q + PC_STEP;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (id_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State register with synchronous reset; abandons any in-flight response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
            instr_q   <= 32'h0;
            if_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            if_pc_q   <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, directed
// corner-case sequences, then random traffic against a PC-stream model.
module tb_instruction_fetch;

    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ready, imem_rvalid;
    logic        if_valid, id_ready, branch_taken;
    logic [63:0] imem_addr, if_pc, branch_target;
    logic [31:0] imem_rdata, if_instruction;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_WIDTH(64), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instruction(if_instruction),
        .if_pc(if_pc), .id_ready(id_ready),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        bit          rst, ir, idr;
        bit          ereq;
        logic [63:0] eaddr;
        bit          evalid;
        logic [63:0] epc;
    } vec_t;

    rsp_t        q[$];
    vec_t        tbl[$];
    int          cyc = 0, lat = 1, last_due = -1;
    int          n_cmp = 0, n_bad = 0, n_xfer = 0;
    logic [63:0] exp_pc = RPC;

    // Memory contents: a fixed word at 0x1004, address-derived elsewhere.
    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == 64'h1004) return 32'h00A00093;
        return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F13;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs, run the memory and the reference model.
    task automatic drive(input bit rst, input bit ir, input bit idr,
                         input bit br, input logic [63:0] bt);
        int d;
        reset = rst; imem_ready = ir; id_ready = idr;
        branch_taken = br; branch_target = bt;
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(q[0].addr);
            void'(q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_req === 1'b1)
            chk("addr_align", {62'd0, imem_addr[1:0]}, 64'd0);
        if (imem_req === 1'b1 && ir) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            q.push_back('{imem_addr, d});
        end
        if (rst) exp_pc = RPC;
        else if (br) exp_pc = bt & ~64'd3;
        else if (if_valid === 1'b1 && idr) begin
            chk("xfer_pc", if_pc, exp_pc);
            chk("xfer_instr", {32'd0, if_instruction},
                {32'd0, word(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            n_xfer++;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle(input bit rst, input bit ir, input bit idr,
                         input bit br, input logic [63:0] bt);
        drive(rst, ir, idr, br, bt);
        finish_cycle();
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (if_valid !== 1'b1 && n < bound) begin
            cycle(0, 1, 0, 0, 64'd0);
            n++;
        end
        chk("wait_valid", {63'd0, if_valid}, 64'd1);
    endtask

    task automatic deliver();
        wait_valid(50);
        cycle(0, 1, 1, 0, 64'd0);
    endtask

    task automatic row(input bit rst, input bit ir, input bit idr,
                       input bit ereq, input logic [63:0] eaddr,
                       input bit evalid, input logic [63:0] epc);
        tbl.push_back('{rst, ir, idr, ereq, eaddr, evalid, epc});
    endtask

    initial begin
        bit saw;
        int n, rnd0;
        logic [63:0] bt;
        bit br;

        // reset, zero-wait streaming, then imem_ready low for 5 cycles
        row(1, 1, 1, 0, 0,         0, 0);
        row(0, 1, 1, 1, 64'h1000,  0, 0);
        row(0, 1, 1, 0, 0,         0, 0);
        row(0, 1, 1, 0, 0,         1, 64'h1000);
        row(0, 1, 1, 1, 64'h1004,  0, 0);
        row(0, 1, 1, 0, 0,         0, 0);
        row(0, 1, 1, 0, 0,         1, 64'h1004);
        row(0, 1, 1, 1, 64'h1008,  0, 0);
        row(0, 1, 1, 0, 0,         0, 0);
        row(0, 1, 1, 0, 0,         1, 64'h1008);
        for (int i = 0; i < 5; i++)
            row(0, 0, 1, 1, 64'h100C, 0, 0);
        row(0, 1, 1, 1, 64'h100C,  0, 0);
        row(0, 1, 1, 0, 0,         0, 0);
        row(0, 1, 1, 0, 0,         1, 64'h100C);

        cycle(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].idr, 0, 64'd0);
            chk($sformatf("t%0d_req", i), {63'd0, imem_req},
                {63'd0, tbl[i].ereq});
            if (tbl[i].ereq)
                chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("t%0d_valid", i), {63'd0, if_valid},
                {63'd0, tbl[i].evalid});
            if (tbl[i].evalid || tbl[i].rst)
                chk($sformatf("t%0d_pc", i), if_pc, tbl[i].epc);
            finish_cycle();
        end

        // decode stall with a held instruction
        cycle(1, 0, 0, 0, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        chk("rst_instr", {32'd0, if_instruction}, 64'd0);
        deliver();
        wait_valid(50);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {63'd0, if_valid}, 64'd1);
            chk("stall_pc", if_pc, 64'h1004);
            chk("stall_instr", {32'd0, if_instruction}, 64'h00A00093);
            chk("stall_req", {63'd0, imem_req}, 64'd0);
            cycle(0, 1, 0, 0, 64'd0);
        end
        cycle(0, 1, 1, 0, 64'd0);
        chk("stall_drop", {63'd0, if_valid}, 64'd0);

        // redirect while waiting; old response arrives two cycles later
        lat = 3;
        chk("b_addr", imem_addr, 64'h1008);
        cycle(0, 1, 0, 0, 64'd0);
        cycle(0, 0, 0, 1, 64'h2003);
        saw = 0; n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            if (if_valid === 1'b1) saw = 1;
            cycle(0, 0, 0, 0, 64'd0);
            n++;
        end
        chk("b_req", {63'd0, imem_req}, 64'd1);
        chk("b_addr2", imem_addr, 64'h2000);
        chk("b_stale", {63'd0, saw}, 64'd0);
        lat = 1;
        wait_valid(50);
        chk("b_pc", if_pc, 64'h2000);
        cycle(0, 1, 1, 0, 64'd0);

        // redirect in the same cycle the request is accepted
        cycle(1, 0, 0, 0, 64'd0);
        deliver(); deliver(); deliver();
        chk("c_req", {63'd0, imem_req}, 64'd1);
        chk("c_addr", imem_addr, 64'h100C);
        cycle(0, 1, 0, 1, 64'h3000);
        saw = 0; n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            if (if_valid === 1'b1) saw = 1;
            cycle(0, 0, 0, 0, 64'd0);
            n++;
        end
        chk("c_addr2", imem_addr, 64'h3000);
        chk("c_stale", {63'd0, saw}, 64'd0);
        wait_valid(50);
        chk("c_pc", if_pc, 64'h3000);
        cycle(0, 1, 1, 0, 64'd0);

        // PC wrap at the top of the address space
        cycle(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid(50);
        chk("w_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 1, 1, 0, 64'd0);
        chk("w_req", {63'd0, imem_req}, 64'd1);
        chk("w_addr2", imem_addr, 64'd0);

        // reset in WAIT, stale response arrives in REQ
        lat = 4;
        cycle(0, 1, 0, 0, 64'd0);
        cycle(1, 0, 0, 0, 64'd0);
        chk("e_rst_req", {63'd0, imem_req}, 64'd0);
        saw = 0; n = 0;
        while (q.size() > 0 && n < 10) begin
            cycle(0, 0, 0, 0, 64'd0);
            if (if_valid === 1'b1) saw = 1;
            n++;
        end
        chk("e_drained", q.size(), 64'd0);
        chk("e_stale", {63'd0, saw}, 64'd0);
        chk("e_req", {63'd0, imem_req}, 64'd1);
        chk("e_addr", imem_addr, RPC);
        lat = 1;
        wait_valid(50);
        chk("e_pc", if_pc, RPC);
        cycle(0, 1, 1, 0, 64'd0);

        // random traffic against the PC-stream model
        rnd0 = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                n = 0;
                do begin
                    cycle(1, 1'($urandom), 1'($urandom), 1'($urandom),
                          {$urandom, $urandom});
                    n++;
                end while ((q.size() > 0 || n < 2) && n < 20);
            end else begin
                lat = $urandom_range(1, 4);
                br  = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0)
                    bt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else
                    bt = {$urandom, $urandom};
                cycle(0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0, br, bt);
            end
        end
        chk("progress", {63'd0, (n_xfer - rnd0) >= 100}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
